// File: rtl/gray_capture_pkg.sv
// rtl/gray_capture_pkg.sv - shared state encoding, mode codes and default frame geometry for the capture path
package gray_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } tCapState;

    localparam logic MODE_COLOR = 1'b0;
    localparam logic MODE_GRAY  = 1'b1;

    localparam int DEF_H_ACT = 640;
    localparam int DEF_V_ACT = 480;

endpackage

// File: rtl/gray_capture_ctrl_if.sv
// rtl/gray_capture_ctrl_if.sv - capture control/status bundle; GRAY_CAPTURE_FRAME_CNT_EN adds the frame statistics
interface gray_capture_ctrl_if #(
    parameter int XW = 10,
    parameter int YW = 9
);
    logic          iSTART;
    logic          iABORT;
    logic          iMODE;
    logic          iFVAL;
    logic          iDVAL;
    logic          oSEL_GRAY;
    logic          oWR_EN;
    logic [XW-1:0] oX;
    logic [YW-1:0] oY;
    logic          oSOF;
    logic          oEOF;
    logic          oBUSY;
    logic          oDONE;
    logic          oERR;
`ifdef GRAY_CAPTURE_FRAME_CNT_EN
    logic [15:0]   oFRAME_CNT;
    logic [7:0]    oFRAME_LOST;
`endif

    modport master (
`ifdef GRAY_CAPTURE_FRAME_CNT_EN
        input  oFRAME_CNT, oFRAME_LOST,
`endif
        output iSTART, iABORT, iMODE, iFVAL, iDVAL,
        input  oSEL_GRAY, oWR_EN, oX, oY, oSOF, oEOF, oBUSY, oDONE, oERR
    );

    modport slave (
`ifdef GRAY_CAPTURE_FRAME_CNT_EN
        output oFRAME_CNT, oFRAME_LOST,
`endif
        input  iSTART, iABORT, iMODE, iFVAL, iDVAL,
        output oSEL_GRAY, oWR_EN, oX, oY, oSOF, oEOF, oBUSY, oDONE, oERR
    );

endinterface

// File: rtl/gray_capture_ctrl_pixel_xy_counter.sv
// rtl/gray_capture_ctrl_pixel_xy_counter.sv - raster x/y counter with clear, enable, wrap and first/last flags
module pixel_xy_counter #(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iCLR,
    input  logic          iEN,
    output logic [XW-1:0] oX,
    output logic [YW-1:0] oY,
    output logic          oFIRST,
    output logic          oLAST
);

    logic xEnd;
    logic yEnd;

    assign xEnd   = (oX == XW'(H_ACT - 1));
    assign yEnd   = (oY == YW'(V_ACT - 1));
    assign oFIRST = (oX == '0) && (oY == '0);
    assign oLAST  = xEnd && yEnd;

    // The frame wraps back to the origin so a readout side can free-run it.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oX <= '0;
            oY <= '0;
        end else if (iCLR) begin
            oX <= '0;
            oY <= '0;
        end else if (iEN) begin
            if (xEnd) begin
                oX <= '0;
                oY <= yEnd ? '0 : oY + YW'(1);
            end else begin
                oX <= oX + XW'(1);
            end
        end
    end

endmodule

// File: rtl/gray_capture_ctrl.sv
// rtl/gray_capture_ctrl.sv - frame capture sequencer; GRAY_CAPTURE_FRAME_CNT_EN adds frame/lost counters
module gray_capture_ctrl
    import gray_capture_pkg::*;
#(
    parameter int H_ACT = DEF_H_ACT,
    parameter int V_ACT = DEF_V_ACT,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic               iCLK,
    input  logic               iRST,
    gray_capture_ctrl_if.slave bus
);

    tCapState      state;
    logic          modeR;
    logic          fvalD;
    logic          fvalRise;
    logic          pixWr;
    logic          cntClr;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          firstPix;
    logic          lastPix;

    assign fvalRise = bus.iFVAL && !fvalD;
    assign pixWr    = (state == CAPTURE) && !bus.iABORT && bus.iFVAL && bus.iDVAL;
    assign cntClr   = (state == ARM) && !bus.iABORT && fvalRise;

    pixel_xy_counter #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT),
        .XW    (XW),
        .YW    (YW)
    ) u_xy (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iCLR   (cntClr),
        .iEN    (pixWr),
        .oX     (x),
        .oY     (y),
        .oFIRST (firstPix),
        .oLAST  (lastPix)
    );

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state         <= IDLE;
            modeR         <= MODE_COLOR;
            fvalD         <= 1'b0;
            bus.oSEL_GRAY <= 1'b0;
            bus.oWR_EN    <= 1'b0;
            bus.oX        <= '0;
            bus.oY        <= '0;
            bus.oSOF      <= 1'b0;
            bus.oEOF      <= 1'b0;
            bus.oBUSY     <= 1'b0;
            bus.oDONE     <= 1'b0;
            bus.oERR      <= 1'b0;
`ifdef GRAY_CAPTURE_FRAME_CNT_EN
            bus.oFRAME_CNT  <= '0;
            bus.oFRAME_LOST <= '0;
`endif
        end else begin
            fvalD      <= bus.iFVAL;
            bus.oWR_EN <= 1'b0;
            bus.oSOF   <= 1'b0;
            bus.oEOF   <= 1'b0;
            bus.oDONE  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.iSTART) begin
                        modeR         <= bus.iMODE;
                        bus.oSEL_GRAY <= (bus.iMODE == MODE_GRAY);
                        bus.oERR      <= 1'b0;
                        bus.oBUSY     <= 1'b1;
                        state         <= ARM;
                    end
                end
                ARM: begin
                    bus.oSEL_GRAY <= (modeR == MODE_GRAY);
                    if (bus.iABORT) begin
                        bus.oSEL_GRAY <= 1'b0;
                        bus.oBUSY     <= 1'b0;
                        state         <= IDLE;
                    end else if (fvalRise) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    bus.oSEL_GRAY <= (modeR == MODE_GRAY);
`ifdef GRAY_CAPTURE_FRAME_CNT_EN
                    if (fvalRise && (bus.oFRAME_LOST != 8'hFF))
                        bus.oFRAME_LOST <= bus.oFRAME_LOST + 8'd1;
`endif
                    // Abort beats a frame end, and a frame end beats a pixel write.
                    if (bus.iABORT) begin
                        bus.oSEL_GRAY <= 1'b0;
                        bus.oBUSY     <= 1'b0;
                        state         <= IDLE;
                    end else if (!bus.iFVAL) begin
                        bus.oERR  <= 1'b1;
                        bus.oBUSY <= 1'b0;
                        state     <= DONE;
                    end else if (bus.iDVAL) begin
                        bus.oWR_EN <= 1'b1;
                        bus.oX     <= x;
                        bus.oY     <= y;
                        bus.oSOF   <= firstPix;
                        bus.oEOF   <= lastPix;
                        if (lastPix) begin
                            bus.oERR  <= 1'b0;
                            bus.oBUSY <= 1'b0;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    bus.oDONE     <= 1'b1;
                    bus.oSEL_GRAY <= 1'b0;
                    state         <= IDLE;
`ifdef GRAY_CAPTURE_FRAME_CNT_EN
                    if (!bus.oERR)
                        bus.oFRAME_CNT <= bus.oFRAME_CNT + 16'd1;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_capture_ctrl.sv
// tb/tb_gray_capture_ctrl.sv - randomized self-checking bench for gray_capture_ctrl against a transaction-level model
module tb_gray_capture_ctrl;

    localparam int H    = 4;
    localparam int V    = 3;
    localparam int NPIX = H * V;

    typedef struct {
        int cyc;
        int x;
        int y;
        int sof;
        int eof;
    } tWr;

    logic iCLK = 1'b0;
    logic iRST = 1'b0;
    always #5 iCLK = ~iCLK;

    gray_capture_ctrl_if #(.XW(2), .YW(2)) bus ();

    gray_capture_ctrl #(
        .H_ACT (H),
        .V_ACT (V),
        .XW    (2),
        .YW    (2)
    ) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    int cyc     = 0;
    int nCmp    = 0;
    int nBad    = 0;
    int expMode = 0;
    int goodCnt = 0;
    tWr wrQ[$];
    int doneCyc[$];
    int doneErr[$];

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nBad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge iCLK) begin
        if (iRST) begin
            if (bus.oWR_EN) begin
                wrQ.push_back('{cyc, int'(bus.oX), int'(bus.oY), int'(bus.oSOF), int'(bus.oEOF)});
                chk("sel_gray_on_write", int'(bus.oSEL_GRAY), expMode);
            end
            if (bus.oDONE) begin
                doneCyc.push_back(cyc);
                doneErr.push_back(int'(bus.oERR));
            end
        end
    end

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        chk({tag, "_busy"}, int'(bus.oBUSY), 0);
        chk({tag, "_wr"}, int'(bus.oWR_EN), 0);
        chk({tag, "_x"}, int'(bus.oX), 0);
        chk({tag, "_y"}, int'(bus.oY), 0);
        chk({tag, "_sel"}, int'(bus.oSEL_GRAY), 0);
        chk({tag, "_done"}, int'(bus.oDONE), 0);
        chk({tag, "_err"}, int'(bus.oERR), 0);
        chk({tag, "_sof"}, int'(bus.oSOF), 0);
        chk({tag, "_eof"}, int'(bus.oEOF), 0);
    endtask

    // Frame model: the first NPIX valid pixels of the frame after the start map
    // to raster order; abort truncates the list and suppresses the done pulse.
    task automatic runCapture(input int mode, input int nPix, input int midStart,
                              input int abortAt, input int extraStart, input int doneStart);
        int expDv[$];
        int fallCyc;
        int nExp;
        int expDone;
        int expDoneCyc;
        int expErr;
        int aborted;
        wrQ.delete();
        doneCyc.delete();
        doneErr.delete();
        expMode = mode;
        aborted = 0;

        if (midStart) begin
            bus.iFVAL = 1'b1;
            bus.iDVAL = 1'b1;
            step();
        end
        bus.iSTART = 1'b1;
        bus.iMODE  = mode[0];
        step();
        chk("start_busy", int'(bus.oBUSY), 1);
        chk("start_sel", int'(bus.oSEL_GRAY), mode);
        chk("start_err_clr", int'(bus.oERR), 0);
        if ($urandom_range(1, 0) == 1) step();
        bus.iSTART = 1'b0;
        bus.iMODE  = 1'($urandom);
        if (midStart) begin
            repeat (2) begin
                bus.iDVAL = 1'($urandom);
                step();
            end
        end
        bus.iFVAL = 1'b0;
        bus.iDVAL = 1'b0;
        repeat ($urandom_range(2, 1)) step();

        bus.iFVAL = 1'b1;
        bus.iDVAL = 1'($urandom);
        step();
        bus.iDVAL = 1'b0;

        for (int i = 0; i < nPix; i++) begin
            repeat ($urandom_range(2, 0)) begin
                bus.iMODE = 1'($urandom);
                if (extraStart != 0 && i > 0 && i < NPIX && aborted == 0)
                    bus.iSTART = 1'($urandom);
                step();
                bus.iSTART = 1'b0;
            end
            bus.iDVAL = 1'b1;
            if (i == abortAt) bus.iABORT = 1'b1;
            expDv.push_back(cyc + 1);
            step();
            bus.iDVAL  = 1'b0;
            bus.iABORT = 1'b0;
            if (i == abortAt) aborted = 1;
            if (doneStart != 0 && i == NPIX - 1) begin
                bus.iSTART = 1'b1;
                step();
                bus.iSTART = 1'b0;
            end
        end
        repeat ($urandom_range(2, 1)) step();
        bus.iFVAL = 1'b0;
        fallCyc   = cyc + 1;
        step();
        repeat (6) step();

        nExp = (nPix < NPIX) ? nPix : NPIX;
        if (abortAt >= 0 && abortAt < nExp) nExp = abortAt;
        if (abortAt >= 0) begin
            expDone = 0; expDoneCyc = 0; expErr = 0;
        end else if (nPix >= NPIX) begin
            expDone = 1; expDoneCyc = expDv[NPIX-1] + 1; expErr = 0;
            goodCnt++;
        end else begin
            expDone = 1; expDoneCyc = fallCyc + 1; expErr = 1;
        end

        chk("wr_count", wrQ.size(), nExp);
        for (int i = 0; i < nExp && i < wrQ.size(); i++) begin
            chk("wr_cycle", wrQ[i].cyc, expDv[i]);
            chk("wr_x", wrQ[i].x, i % H);
            chk("wr_y", wrQ[i].y, i / H);
            chk("wr_sof", wrQ[i].sof, (i == 0) ? 1 : 0);
            chk("wr_eof", wrQ[i].eof, (i == NPIX - 1) ? 1 : 0);
        end
        chk("done_count", doneCyc.size(), expDone);
        if (expDone == 1 && doneCyc.size() == 1) begin
            chk("done_cycle", doneCyc[0], expDoneCyc);
            chk("done_err", doneErr[0], expErr);
        end
        chk("end_busy", int'(bus.oBUSY), 0);
        chk("end_sel", int'(bus.oSEL_GRAY), 0);
        chk("end_err_hold", int'(bus.oERR), expErr);
`ifdef GRAY_CAPTURE_FRAME_CNT_EN
        chk("frame_cnt", int'(bus.oFRAME_CNT), goodCnt & 32'hFFFF);
        chk("frame_lost", int'(bus.oFRAME_LOST), 0);
`endif
    endtask

    task automatic resetMidCapture();
        bus.iSTART = 1'b1;
        bus.iMODE  = 1'b1;
        expMode    = 1;
        step();
        bus.iSTART = 1'b0;
        step();
        bus.iFVAL = 1'b1;
        step();
        for (int i = 0; i < 7; i++) begin
            bus.iDVAL = 1'b1;
            step();
        end
        bus.iDVAL = 1'b0;
        chk("pre_rst_x", int'(bus.oX), 2);
        chk("pre_rst_y", int'(bus.oY), 1);
        chk("pre_rst_busy", int'(bus.oBUSY), 1);
        #2 iRST = 1'b0;
        #1 checkIdleOutputs("async_rst");
        bus.iFVAL = 1'b0;
        step();
        iRST    = 1'b1;
        goodCnt = 0;
        step();
        checkIdleOutputs("post_rst");
    endtask

    initial begin
        int nPix;
        int sel;
        int ab;
        int lim;
        bus.iSTART = 1'b0;
        bus.iABORT = 1'b0;
        bus.iMODE  = 1'b0;
        bus.iFVAL  = 1'b0;
        bus.iDVAL  = 1'b0;
        #1 checkIdleOutputs("reset");
        repeat (3) step();
        iRST = 1'b1;
        step();
        checkIdleOutputs("after_reset");
`ifdef GRAY_CAPTURE_FRAME_CNT_EN
        chk("reset_frame_cnt", int'(bus.oFRAME_CNT), 0);
`endif

        runCapture(1, NPIX,     0, -1, 0, 0);
        runCapture(0, NPIX,     1, -1, 0, 1);
        runCapture(1, 7,        0, -1, 0, 0);
        runCapture(0, NPIX,     0,  6, 1, 0);
        runCapture(1, NPIX + 3, 0, -1, 1, 1);
        runCapture(0, NPIX,     0, NPIX - 1, 0, 0);
        runCapture(1, NPIX,     0,  0, 0, 0);
        resetMidCapture();
        runCapture(1, NPIX,     0, -1, 0, 0);

        for (int n = 0; n < 24; n++) begin
            sel  = $urandom_range(2, 0);
            nPix = (sel == 0) ? NPIX : (sel == 1) ? NPIX + $urandom_range(3, 0) : $urandom_range(NPIX - 1, 1);
            lim  = (nPix < NPIX) ? nPix : NPIX;
            ab   = ($urandom_range(3, 0) == 0) ? $urandom_range(lim - 1, 0) : -1;
            runCapture($urandom_range(1, 0), nPix, $urandom_range(1, 0), ab,
                       $urandom_range(1, 0), (nPix >= NPIX && ab < 0) ? $urandom_range(1, 0) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
